// File: rtl/inst_loader.sv
// Streams a program into instruction memory via the inst_control write port.
// Define INST_LOADER_CHECKSUM_EN to enable the XOR checksum of loaded words.
module inst_loader #(
  parameter int unsigned RegAddrWidth     = 32,
  parameter int unsigned InstMemDepth     = 128,
  parameter int unsigned InstMemAddrWidth = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clr_i,
  input  logic                        load_start_i,
  input  logic [InstMemAddrWidth-1:0] load_base_addr_i,
  input  logic [InstMemAddrWidth-1:0] load_len_i,
  input  logic [RegAddrWidth-1:0]     prog_data_i,
  input  logic                        prog_valid_i,
  output logic                        prog_ready_o,
  output logic                        inst_wr_mode_o,
  output logic [InstMemAddrWidth-1:0] inst_wr_addr_o,
  output logic                        inst_wr_addr_en_o,
  output logic [RegAddrWidth-1:0]     inst_wr_data_o,
  output logic                        inst_wr_data_en_o,
  output logic                        inst_pc_reset_o,
  output logic                        load_busy_o,
  output logic                        load_done_o,
  output logic                        load_err_o,
  output logic [RegAddrWidth-1:0]     checksum_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SET_ADDR,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam int unsigned SW = InstMemAddrWidth + 1;
  localparam logic [SW-1:0] DepthW = SW'(InstMemDepth);

  state_e r_state, w_next;

  logic [InstMemAddrWidth-1:0] r_rem;
  logic [SW-1:0]               w_sum;
  logic w_len_err, w_start, w_ok, w_err;
  logic w_hs, w_last;
  logic w_mode, w_addr_en, w_done, w_busy;

  // Sum is one bit wider so base+len cannot wrap past the depth check.
  assign w_sum     = {1'b0, load_base_addr_i} + {1'b0, load_len_i};
  assign w_len_err = (load_len_i == '0) || (w_sum > DepthW);
  assign w_start   = (r_state == S_IDLE) && load_start_i && !clr_i;
  assign w_ok      = w_start && !w_len_err;
  assign w_err     = w_start && w_len_err;
  assign w_hs      = prog_valid_i && (r_state == S_STREAM) && !clr_i;
  assign w_last    = w_hs && (r_rem == InstMemAddrWidth'(1));

  assign prog_ready_o = (r_state == S_STREAM);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (clr_i) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:     if (w_ok) w_next = S_SET_ADDR;
        S_SET_ADDR: w_next = S_STREAM;
        S_STREAM:   if (w_last) w_next = S_DRAIN;
        S_DRAIN:    w_next = S_DONE;
        S_DONE:     w_next = S_IDLE;
        default:    w_next = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state, then registered.
  always_comb begin
    w_mode    = (w_next == S_SET_ADDR) ||
                (w_next == S_STREAM)   ||
                (w_next == S_DRAIN);
    w_addr_en = (w_next == S_SET_ADDR);
    w_done    = (w_next == S_DONE);
    w_busy    = (w_next != S_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inst_wr_mode_o    <= 1'b0;
      inst_wr_addr_o    <= '0;
      inst_wr_addr_en_o <= 1'b0;
      inst_wr_data_o    <= '0;
      inst_wr_data_en_o <= 1'b0;
      inst_pc_reset_o   <= 1'b0;
      load_busy_o       <= 1'b0;
      load_done_o       <= 1'b0;
      load_err_o        <= 1'b0;
      r_rem             <= '0;
    end else begin
      inst_wr_mode_o    <= w_mode;
      inst_wr_addr_en_o <= w_addr_en;
      inst_wr_data_en_o <= w_hs;
      inst_pc_reset_o   <= w_done;
      load_busy_o       <= w_busy;
      load_done_o       <= w_done;
      load_err_o        <= w_err;
      if (w_ok) inst_wr_addr_o <= load_base_addr_i;
      if (w_hs) inst_wr_data_o <= prog_data_i;
      if (clr_i)     r_rem <= '0;
      else if (w_ok) r_rem <= load_len_i;
      else if (w_hs) r_rem <= r_rem - InstMemAddrWidth'(1);
    end
  end

`ifdef INST_LOADER_CHECKSUM_EN
  logic [RegAddrWidth-1:0] r_csum;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)    r_csum <= '0;
    else if (clr_i) r_csum <= '0;
    else if (w_ok)  r_csum <= '0;
    else if (w_hs)  r_csum <= r_csum ^ prog_data_i;
  end

  assign checksum_o = r_csum;
`else
  assign checksum_o = '0;
`endif

endmodule

// File: tb/tb_inst_loader.sv
// Directed self-checking bench for inst_loader.
// Covers load, bubbles, bounds, abort, ignored start and checksum.
module tb_inst_loader;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        start;
  logic [7:0]  base;
  logic [7:0]  len;
  logic [31:0] pdata;
  logic        pvalid;
  logic        pready;
  logic        wmode;
  logic [7:0]  waddr;
  logic        waddr_en;
  logic [31:0] wdata;
  logic        wdata_en;
  logic        pc_rst;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] csum;

  int n_chk;
  int n_fail;

  inst_loader dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .clr_i             (clr),
    .load_start_i      (start),
    .load_base_addr_i  (base),
    .load_len_i        (len),
    .prog_data_i       (pdata),
    .prog_valid_i      (pvalid),
    .prog_ready_o      (pready),
    .inst_wr_mode_o    (wmode),
    .inst_wr_addr_o    (waddr),
    .inst_wr_addr_en_o (waddr_en),
    .inst_wr_data_o    (wdata),
    .inst_wr_data_en_o (wdata_en),
    .inst_pc_reset_o   (pc_rst),
    .load_busy_o       (busy),
    .load_done_o       (done),
    .load_err_o        (err),
    .checksum_o        (csum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] exp_cs;
    logic [4:0]  pat;
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    clr    = 1'b0;
    start  = 1'b0;
    base   = '0;
    len    = '0;
    pdata  = '0;
    pvalid = 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
    exp_cs = 32'hF7;
`else
    exp_cs = 32'h0;
`endif

    // reset
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_mode", wmode, 0);
    chk("rst_aen", waddr_en, 0);
    chk("rst_den", wdata_en, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_pcr", pc_rst, 0);
    chk("rst_rdy", pready, 0);
    chk("rst_cs", csum, 0);
    chk("rst_addr", waddr, 0);
    rst_n = 1'b1;
    tick();

    // basic load: base 0x10, len 4
    start = 1; base = 8'h10; len = 8'd4;
    tick();
    start = 0;
    chk("b_aen", waddr_en, 1);
    chk("b_addr", waddr, 32'h10);
    chk("b_mode", wmode, 1);
    chk("b_busy", busy, 1);
    chk("b_rdy0", pready, 0);
    pvalid = 1; pdata = 32'hA0;
    tick();
    chk("b_rdy1", pready, 1);
    chk("b_den0", wdata_en, 0);
    chk("b_aen0", waddr_en, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("b_den", wdata_en, 1);
      chk("b_data", wdata, 32'hA0 + i);
      chk("b_rdy", pready, (i < 3) ? 1 : 0);
      chk("b_mode_s", wmode, 1);
      chk("b_done_s", done, 0);
      pdata  = 32'hA1 + i;
      pvalid = (i < 3);
    end
    tick();
    chk("b_done", done, 1);
    chk("b_pcr", pc_rst, 1);
    chk("b_mode_d", wmode, 0);
    chk("b_busy_d", busy, 1);
    chk("b_den_d", wdata_en, 0);
    tick();
    chk("b_busy_i", busy, 0);
    chk("b_done_i", done, 0);
    chk("b_pcr_i", pc_rst, 0);

    // bubbles: base 0, len 3, valid 1-0-1-0-1
    start = 1; base = 8'h00; len = 8'd3;
    tick();
    start = 0;
    chk("u_aen", waddr_en, 1);
    chk("u_addr", waddr, 0);
    tick();
    chk("u_rdy", pready, 1);
    pat = 5'b10101;
    for (int c = 0; c < 5; c++) begin
      pvalid = pat[c];
      pdata  = 32'hB0 + c;
      tick();
      chk("u_den", wdata_en, pat[c]);
      if (pat[c]) chk("u_data", wdata, 32'hB0 + c);
      chk("u_rdy_c", pready, (c < 4) ? 1 : 0);
    end
    pvalid = 0;
    chk("u_drain_mode", wmode, 1);
    tick();
    chk("u_done", done, 1);
    chk("u_den_d", wdata_en, 0);
    tick();
    chk("u_idle", busy, 0);

    // bounds: len 0
    start = 1; base = 8'h00; len = 8'd0;
    tick();
    start = 0;
    chk("e0_err", err, 1);
    chk("e0_busy", busy, 0);
    chk("e0_aen", waddr_en, 0);
    tick();
    chk("e0_err_clr", err, 0);
    chk("e0_den", wdata_en, 0);

    // bounds: 120 + 9 > 128
    start = 1; base = 8'd120; len = 8'd9;
    tick();
    start = 0;
    chk("e9_err", err, 1);
    chk("e9_busy", busy, 0);
    tick();
    chk("e9_err_clr", err, 0);

    // bounds: 120 + 8 == 128 is legal
    start = 1; base = 8'd120; len = 8'd8;
    tick();
    start = 0;
    chk("m_err", err, 0);
    chk("m_aen", waddr_en, 1);
    chk("m_addr", waddr, 120);
    pvalid = 1; pdata = 32'hC0;
    tick();
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("m_den", wdata_en, 1);
      chk("m_data", wdata, 32'hC0 + i);
      pdata  = 32'hC1 + i;
      pvalid = (i < 7);
    end
    tick();
    chk("m_done", done, 1);
    tick();

    // abort after 3 words of an 8-word load
    start = 1; base = 8'h00; len = 8'd8;
    tick();
    start = 0;
    pvalid = 1; pdata = 32'hD0;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("a_den", wdata_en, 1);
      pdata = 32'hD1 + i;
    end
    clr = 1;
    tick();
    clr = 0; pvalid = 0;
    chk("a_busy", busy, 0);
    chk("a_den_c", wdata_en, 0);
    chk("a_mode", wmode, 0);
    chk("a_done", done, 0);
    chk("a_pcr", pc_rst, 0);
    chk("a_err", err, 0);
    chk("a_rdy", pready, 0);
    chk("a_cs", csum, 0);
    tick();
    chk("a_done2", done, 0);
    chk("a_pcr2", pc_rst, 0);
    start = 1; base = 8'h04; len = 8'd2;
    tick();
    start = 0;
    chk("a2_addr", waddr, 4);
    chk("a2_aen", waddr_en, 1);
    pvalid = 1; pdata = 32'hE0;
    tick();
    tick();
    chk("a2_d0", wdata, 32'hE0);
    pdata = 32'hE1;
    tick();
    pvalid = 0;
    chk("a2_d1", wdata, 32'hE1);
    chk("a2_den1", wdata_en, 1);
    tick();
    chk("a2_done", done, 1);
    chk("a2_pcr", pc_rst, 1);
    tick();

    // start while streaming is ignored
    start = 1; base = 8'h20; len = 8'd2;
    tick();
    start = 0;
    pvalid = 1; pdata = 32'h11;
    tick();
    start = 1; base = 8'h50; len = 8'd5;
    tick();
    start = 0; pdata = 32'h22;
    chk("i_den0", wdata_en, 1);
    chk("i_err", err, 0);
    chk("i_addr", waddr, 32'h20);
    tick();
    pvalid = 0;
    chk("i_den1", wdata_en, 1);
    chk("i_data1", wdata, 32'h22);
    tick();
    chk("i_done", done, 1);
    chk("i_addr2", waddr, 32'h20);
    tick();
    chk("i_idle", busy, 0);

    // clr and start together
    clr = 1; start = 1; base = 8'h00; len = 8'd1;
    tick();
    clr = 0; start = 0;
    chk("cs_busy", busy, 0);
    chk("cs_aen", waddr_en, 0);
    chk("cs_err", err, 0);
    tick();
    chk("cs_busy2", busy, 0);
    chk("cs_aen2", waddr_en, 0);

    // checksum over 1, 2, 4, 0xF0
    start = 1; base = 8'h00; len = 8'd4;
    tick();
    start = 0;
    pvalid = 1; pdata = 32'h1;
    tick();
    tick();
    pdata = 32'h2;
    tick();
    pdata = 32'h4;
    tick();
    pdata = 32'hF0;
    tick();
    pvalid = 0;
    chk("k_den", wdata_en, 1);
    chk("k_data", wdata, 32'hF0);
    tick();
    chk("k_done", done, 1);
    chk("k_cs", csum, exp_cs);
    tick();
    tick();
    chk("k_cs_hold", csum, exp_cs);
    chk("k_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
